multi_edge_debounce: RTL and testbench

MULTI_EDGE_DEBOUNCE -- requirements
Module: multi_edge_debounce

---
 rtl/multi_edge_debounce_pkg.sv | 13 +
 rtl/debounce_channel.sv | 126 ++++++++++++
 rtl/multi_edge_debounce.sv | 53 +++++
 tb/tb_multi_edge_debounce.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_debounce_pkg.sv
// Shared encodings for the multi-channel debounce filter: per-channel FSM
// states and the symmetric/separate hold-time selection.
package multi_edge_debounce_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_QUAL = 1'b1
    } state_e;

    localparam logic SYM_SEPARATE = 1'b0;
    localparam logic SYM_SHARED   = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, IDLE/QUAL qualification FSM with
// delay counter, and registered level/edge outputs.
module debounce_channel
    import multi_edge_debounce_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             din,
    input  logic             force_ch,
    input  logic [WIDTH-1:0] rise_t,
    input  logic [WIDTH-1:0] fall_t,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             glitch_pulse,
    output logic             busy
);

    logic             sync_s;
    logic             mis_s;
    logic [WIDTH-1:0] target_s;
    state_e           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic             filt_r;
    logic             glitch_r;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Synchroniser shift chain; keeps sampling even while filtering is frozen.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_r <= {SYNC_STAGES{INIT}};
                end else begin
                    sync_r[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign sync_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // The FSM compares against its own level (filt_r); level_out is one register later.
    assign target_s = filt_r ? fall_t : rise_t;
    assign mis_s    = (sync_s != filt_r) || force_ch;

    // Qualification FSM, delay counter and glitch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {WIDTH{1'b0}};
            filt_r   <= INIT;
            glitch_r <= 1'b0;
        end else if (!enable) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {WIDTH{1'b0}};
            glitch_r <= 1'b0;
        end else begin
            glitch_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mis_s) begin
                        if (target_s == {WIDTH{1'b0}}) begin
                            filt_r <= ~filt_r;
                        end else begin
                            state_r <= ST_QUAL;
                            cnt_r   <= WIDTH'(1);
                        end
                    end
                end
                ST_QUAL: begin
                    if (!mis_s) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= {WIDTH{1'b0}};
                        glitch_r <= 1'b1;
                    end else if (cnt_r >= target_s) begin
                        // >= lets a delay lowered mid-qualification complete at once.
                        state_r <= ST_IDLE;
                        cnt_r   <= {WIDTH{1'b0}};
                        filt_r  <= ~filt_r;
                    end else begin
                        cnt_r <= cnt_r + WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Output level and edge pulses, aligned to the cycle level_out changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= INIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            level_r <= filt_r;
            rise_r  <= filt_r & ~level_r;
            fall_r  <= ~filt_r & level_r;
        end
    end

    assign level_out    = level_r;
    assign rise_pulse   = rise_r;
    assign fall_pulse   = fall_r;
    assign glitch_pulse = glitch_r;
    assign busy         = (state_r == ST_QUAL);

endmodule

// File: rtl/multi_edge_debounce.sv
// CH-channel debounce filter: selects the fall target (shared or separate)
// and instantiates one independent debounce_channel per input bit.
module multi_edge_debounce
    import multi_edge_debounce_pkg::*;
#(
    parameter int            CH          = 8,
    parameter int            WIDTH       = 8,
    parameter int            SYNC_STAGES = 2,
    parameter logic [CH-1:0] INIT_LEVEL  = {CH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sym_mode,
    input  logic [WIDTH-1:0] rise_delay,
    input  logic [WIDTH-1:0] fall_delay,
    input  logic [CH-1:0]    din,
    input  logic [CH-1:0]    force_ch,
    output logic [CH-1:0]    level_out,
    output logic [CH-1:0]    rise_pulse,
    output logic [CH-1:0]    fall_pulse,
    output logic [CH-1:0]    glitch_pulse,
    output logic [CH-1:0]    busy
);

    logic [WIDTH-1:0] fall_t_s;

    assign fall_t_s = (sym_mode == SYM_SHARED) ? rise_delay : fall_delay;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            debounce_channel #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES),
                .INIT        (INIT_LEVEL[i])
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .enable       (enable),
                .din          (din[i]),
                .force_ch     (force_ch[i]),
                .rise_t       (rise_delay),
                .fall_t       (fall_t_s),
                .level_out    (level_out[i]),
                .rise_pulse   (rise_pulse[i]),
                .fall_pulse   (fall_pulse[i]),
                .glitch_pulse (glitch_pulse[i]),
                .busy         (busy[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_debounce.sv
// Directed self-checking bench for multi_edge_debounce: latency table plus
// hand-written glitch, width, delay-change, reset, enable and force sequences.
module tb_multi_edge_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sym_mode;
    logic [7:0] rise_delay;
    logic [7:0] fall_delay;
    logic [7:0] din;
    logic [7:0] force_ch;
    logic [7:0] level_out;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic [7:0] glitch_pulse;
    logic [7:0] busy;

    int checks   = 0;
    int failures = 0;

    multi_edge_debounce dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sym_mode     (sym_mode),
        .rise_delay   (rise_delay),
        .fall_delay   (fall_delay),
        .din          (din),
        .force_ch     (force_ch),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .glitch_pulse (glitch_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic       sym;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       to_high;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din      = 8'h00;
        force_ch = 8'h00;
        enable   = 1'b1;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int         k;
        int         cnt_a;
        int         cnt_b;
        int         cnt_c;
        logic       changed;
        logic       prev;
        logic [7:0] acc;
        int         tog[8];

        // latency = edges after the first sampling edge until level_out changes
        vecs[0] = '{0, 1'b0, 8'd4,   8'd0,   1'b1, 7};
        vecs[1] = '{1, 1'b0, 8'd0,   8'd0,   1'b1, 3};
        vecs[2] = '{2, 1'b0, 8'd2,   8'd6,   1'b1, 5};
        vecs[3] = '{2, 1'b0, 8'd2,   8'd6,   1'b0, 9};
        vecs[4] = '{3, 1'b1, 8'd3,   8'd9,   1'b0, 6};
        vecs[5] = '{7, 1'b0, 8'd255, 8'd0,   1'b1, 258};
        vecs[6] = '{4, 1'b0, 8'd0,   8'd0,   1'b0, 3};
        vecs[7] = '{5, 1'b1, 8'd0,   8'd200, 1'b0, 3};

        sym_mode   = 1'b0;
        rise_delay = 8'd0;
        fall_delay = 8'd0;
        din        = 8'h00;
        force_ch   = 8'h00;
        enable     = 1'b1;
        rst        = 1'b1;
        tick();
        check("reset_level",  32'(level_out),    32'd0);
        check("reset_rise",   32'(rise_pulse),   32'd0);
        check("reset_fall",   32'(fall_pulse),   32'd0);
        check("reset_glitch", 32'(glitch_pulse), 32'd0);
        check("reset_busy",   32'(busy),         32'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            sym_mode   = vecs[v].sym;
            rise_delay = vecs[v].rise;
            fall_delay = vecs[v].fall;
            if (!vecs[v].to_high) begin
                din[vecs[v].ch] = 1'b1;
                k = 0;
                while (k < 400 && level_out[vecs[v].ch] !== 1'b1) begin
                    tick();
                    k++;
                end
                check("vec_prep_high", 32'(level_out[vecs[v].ch]), 32'd1);
                tick();
            end
            din[vecs[v].ch] = vecs[v].to_high;
            tick();
            k = 0;
            changed = 1'b0;
            while (k < 400 && !changed) begin
                tick();
                k++;
                if (level_out[vecs[v].ch] === vecs[v].to_high) changed = 1'b1;
            end
            check("vec_latency", 32'(k), 32'(vecs[v].exp_lat));
            check("vec_pulse_on",  32'(vecs[v].to_high ? rise_pulse[vecs[v].ch] : fall_pulse[vecs[v].ch]), 32'd1);
            check("vec_pulse_off", 32'(vecs[v].to_high ? fall_pulse[vecs[v].ch] : rise_pulse[vecs[v].ch]), 32'd0);
            acc = level_out;
            acc[vecs[v].ch] = 1'b0;
            check("vec_other_ch", 32'(acc), 32'd0);
            tick();
            check("vec_pulse_1cyc", 32'(rise_pulse[vecs[v].ch] | fall_pulse[vecs[v].ch]), 32'd0);
        end

        // glitch: 3-cycle high against a 5-cycle rise delay
        do_reset();
        sym_mode = 1'b0; rise_delay = 8'd5; fall_delay = 8'd5;
        din[1] = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) din[1] = 1'b0;
            tick();
            cnt_a += int'(busy[1]);
            cnt_b += int'(glitch_pulse[1]);
            cnt_c += int'(level_out[1]);
        end
        check("glitch_busy_cycles", 32'(cnt_a), 32'd3);
        check("glitch_pulses",      32'(cnt_b), 32'd1);
        check("glitch_level",       32'(cnt_c), 32'd0);

        // asymmetric delays: 20-cycle pulse, rise +5, fall +9 -> 24 cycles high
        do_reset();
        sym_mode = 1'b0; rise_delay = 8'd2; fall_delay = 8'd6;
        din[2] = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) din[2] = 1'b0;
            tick();
            cnt_a += int'(level_out[2]);
            cnt_b += int'(rise_pulse[2]);
            cnt_c += int'(fall_pulse[2]);
        end
        check("asym_high_width", 32'(cnt_a), 32'd24);
        check("asym_rise_cnt",   32'(cnt_b), 32'd1);
        check("asym_fall_cnt",   32'(cnt_c), 32'd1);

        // symmetric mode ignores fall_delay: width preserved
        do_reset();
        sym_mode = 1'b1; rise_delay = 8'd3; fall_delay = 8'd9;
        din[3] = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) din[3] = 1'b0;
            tick();
            cnt_a += int'(level_out[3]);
        end
        check("sym_high_width", 32'(cnt_a), 32'd10);

        // delay lowered from 10 to 4 when cnt=6
        do_reset();
        sym_mode = 1'b0; rise_delay = 8'd10; fall_delay = 8'd10;
        din[3] = 1'b1;
        tick();
        repeat (7) tick();
        check("dchg_busy", 32'(busy[3]), 32'd1);
        rise_delay = 8'd4;
        tick();
        check("dchg_level_pre", 32'(level_out[3]), 32'd0);
        tick();
        check("dchg_level_post", 32'(level_out[3]), 32'd1);
        check("dchg_rise_pulse", 32'(rise_pulse[3]), 32'd1);

        // reset asserted with cnt=3
        do_reset();
        sym_mode = 1'b0; rise_delay = 8'd10; fall_delay = 8'd10;
        din[4] = 1'b1;
        tick();
        repeat (4) tick();
        check("rstq_busy_before", 32'(busy[4]), 32'd1);
        rst = 1'b1;
        #1;
        check("rstq_busy_async", 32'(busy[4]), 32'd0);
        acc = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc = acc | rise_pulse | fall_pulse | glitch_pulse | level_out;
        end
        check("rstq_no_pulses", 32'(acc), 32'd0);
        check("rstq_requal_busy", 32'(busy[4]), 32'd1);

        // enable dropped mid-qualification
        do_reset();
        sym_mode = 1'b0; rise_delay = 8'd10; fall_delay = 8'd10;
        din[5] = 1'b1;
        tick();
        repeat (5) tick();
        check("en_busy_before", 32'(busy[5]), 32'd1);
        enable = 1'b0;
        tick();
        check("en_busy_off", 32'(busy[5]), 32'd0);
        acc = 8'h00;
        for (int i = 0; i < 15; i++) begin
            tick();
            acc = acc | rise_pulse | fall_pulse | glitch_pulse | level_out | busy;
        end
        check("en_frozen", 32'(acc), 32'd0);
        enable = 1'b1;
        k = 0;
        while (k < 100 && level_out[5] !== 1'b1) begin
            tick();
            k++;
        end
        check("en_full_requal", 32'(k), 32'd12);

        // sustained force oscillates with period T+1 = 3
        do_reset();
        sym_mode = 1'b1; rise_delay = 8'd2; fall_delay = 8'd0;
        force_ch[6] = 1'b1;
        prev = level_out[6];
        cnt_a = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (level_out[6] !== prev) begin
                if (cnt_a < 8) tog[cnt_a] = i;
                cnt_a++;
                check("force_pulse", 32'(level_out[6] ? rise_pulse[6] : fall_pulse[6]), 32'd1);
                prev = level_out[6];
            end
        end
        check("force_toggles", 32'(cnt_a), 32'd4);
        if (cnt_a >= 4) begin
            check("force_first", 32'(tog[0]), 32'd4);
            for (int j = 1; j < 4; j++) check("force_period", 32'(tog[j] - tog[j-1]), 32'd3);
        end
        force_ch = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
